cmpl_acc_dump: RTL and testbench

Complex integrate-and-dump stage placed directly downstream of the complex multiplier (cmplMult). It consumes the multiplier's valid-qualified product stream (ovalid/result_r/result_i) and accumulates a programmable number of products, N. It then emits one scaled, saturated complex sum per frame, for correlator and despreading chains. Each dump is flagged with a one-cycle output valid.

---
 rtl/cmpl_acc_dump.sv | 154 +++++++++++++++
 tb/tb_cmpl_acc_dump.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/cmpl_acc_dump.sv
// Complex integrate-and-dump: sums N valid products, then emits one shifted, saturated sum.
// Optional macro CMPL_ACC_ROUND_EN selects round-half-up instead of a floor shift at dump.
module cmpl_acc_dump #(
  parameter int IN_WIDTH  = 32,
  parameter int ACC_WIDTH = 40,
  parameter int OUT_WIDTH = 32,
  parameter int SHIFT     = 0,
  parameter int LEN_WIDTH = 8
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        ivalid,
  input  logic                        clear,
  input  logic [LEN_WIDTH-1:0]        acc_len,
  input  logic signed [IN_WIDTH-1:0]  data_r,
  input  logic signed [IN_WIDTH-1:0]  data_i,
  output logic                        ovalid,
  output logic signed [OUT_WIDTH-1:0] result_r,
  output logic signed [OUT_WIDTH-1:0] result_i,
  output logic                        overflow
);

  typedef enum logic {IDLE, ACCUM} state_t;

  localparam logic signed [ACC_WIDTH:0] SAT_MAX =
    $signed({{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}});
  localparam logic signed [ACC_WIDTH:0] SAT_MIN =
    $signed({{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}});

  // Returns {clamped, value}; one guard bit keeps the rounding add from wrapping.
  function automatic logic [OUT_WIDTH:0] scale_sat(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH:0] t;
`ifdef CMPL_ACC_ROUND_EN
    logic signed [ACC_WIDTH:0] rnd;
    rnd = (ACC_WIDTH+1)'((1 << SHIFT) >> 1);
    t = $signed({v[ACC_WIDTH-1], v}) + rnd;
`else
    t = $signed({v[ACC_WIDTH-1], v});
`endif
    t = t >>> SHIFT;
    if (t > SAT_MAX)      scale_sat = {1'b1, SAT_MAX[OUT_WIDTH-1:0]};
    else if (t < SAT_MIN) scale_sat = {1'b1, SAT_MIN[OUT_WIDTH-1:0]};
    else                  scale_sat = {1'b0, t[OUT_WIDTH-1:0]};
  endfunction

  state_t                      state_q, state_d;
  logic [LEN_WIDTH-1:0]        len_q, len_d, cnt_q, cnt_d, len_eff;
  logic signed [ACC_WIDTH-1:0] acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic signed [ACC_WIDTH-1:0] ext_r, ext_i, sum_r, sum_i;
  logic                        vld_p0_d, vld_p0_q;
  logic signed [ACC_WIDTH-1:0] dump_r_p0_d, dump_i_p0_d, dump_r_p0_q, dump_i_p0_q;
  logic [OUT_WIDTH:0]          sat_r, sat_i;
  logic                        ovalid_d, ovalid_q, ovf_d, ovf_q;
  logic signed [OUT_WIDTH-1:0] res_r_d, res_r_q, res_i_d, res_i_q;

  assign ext_r   = {{(ACC_WIDTH-IN_WIDTH){data_r[IN_WIDTH-1]}}, data_r};
  assign ext_i   = {{(ACC_WIDTH-IN_WIDTH){data_i[IN_WIDTH-1]}}, data_i};
  assign sum_r   = acc_r_q + ext_r;
  assign sum_i   = acc_i_q + ext_i;
  assign len_eff = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_r_d     = acc_r_q;
    acc_i_d     = acc_i_q;
    vld_p0_d    = 1'b0;
    dump_r_p0_d = sum_r;
    dump_i_p0_d = sum_i;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      acc_r_d = '0;
      acc_i_d = '0;
    end
    if (ivalid) begin
      // A sample arriving with clear starts a fresh frame.
      if (clear || state_q == IDLE) begin
        len_d = len_eff;
        if (len_eff == LEN_WIDTH'(1)) begin
          vld_p0_d    = 1'b1;
          dump_r_p0_d = ext_r;
          dump_i_p0_d = ext_i;
          state_d     = IDLE;
        end else begin
          acc_r_d = ext_r;
          acc_i_d = ext_i;
          cnt_d   = LEN_WIDTH'(1);
          state_d = ACCUM;
        end
      end else if (cnt_q == len_q - LEN_WIDTH'(1)) begin
        vld_p0_d = 1'b1;
        state_d  = IDLE;
        cnt_d    = '0;
        acc_r_d  = '0;
        acc_i_d  = '0;
      end else begin
        acc_r_d = sum_r;
        acc_i_d = sum_i;
        cnt_d   = cnt_q + LEN_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sat_r    = scale_sat(dump_r_p0_q);
    sat_i    = scale_sat(dump_i_p0_q);
    ovalid_d = vld_p0_q;
    res_r_d  = vld_p0_q ? $signed(sat_r[OUT_WIDTH-1:0]) : res_r_q;
    res_i_d  = vld_p0_q ? $signed(sat_i[OUT_WIDTH-1:0]) : res_i_q;
    ovf_d    = vld_p0_q & (sat_r[OUT_WIDTH] | sat_i[OUT_WIDTH]);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      len_q    <= LEN_WIDTH'(1);
      cnt_q    <= '0;
      acc_r_q  <= '0;
      acc_i_q  <= '0;
      vld_p0_q <= 1'b0;
      ovalid_q <= 1'b0;
      res_r_q  <= '0;
      res_i_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      acc_r_q  <= acc_r_d;
      acc_i_q  <= acc_i_d;
      vld_p0_q <= vld_p0_d;
      ovalid_q <= ovalid_d;
      res_r_q  <= res_r_d;
      res_i_q  <= res_i_d;
      ovf_q    <= ovf_d;
    end
  end

  // p0 -> p1: the frame sum is scaled and saturated one cycle after the last sample.
  always_ff @(posedge clock) begin
    if (vld_p0_d) begin
      dump_r_p0_q <= dump_r_p0_d;
      dump_i_p0_q <= dump_i_p0_d;
    end
  end

  assign ovalid   = ovalid_q;
  assign result_r = res_r_q;
  assign result_i = res_i_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cmpl_acc_dump.sv
// Directed bench for cmpl_acc_dump: default, 16-bit-output and SHIFT=2 instances share stimulus.
module tb_cmpl_acc_dump;

  logic              clock, reset, ivalid, clear;
  logic [7:0]        acc_len;
  logic signed [31:0] data_r, data_i;

  logic               ov0, of0, ov1, of1, ov2, of2;
  logic signed [31:0] r0, i0, r2, i2;
  logic signed [15:0] r1, i1;

  int n_checks = 0;
  int n_fail   = 0;

  cmpl_acc_dump u0 (
    .clock(clock), .reset(reset), .ivalid(ivalid), .clear(clear), .acc_len(acc_len),
    .data_r(data_r), .data_i(data_i), .ovalid(ov0), .result_r(r0), .result_i(i0), .overflow(of0));

  cmpl_acc_dump #(.OUT_WIDTH(16)) u1 (
    .clock(clock), .reset(reset), .ivalid(ivalid), .clear(clear), .acc_len(acc_len),
    .data_r(data_r), .data_i(data_i), .ovalid(ov1), .result_r(r1), .result_i(i1), .overflow(of1));

  cmpl_acc_dump #(.SHIFT(2)) u2 (
    .clock(clock), .reset(reset), .ivalid(ivalid), .clear(clear), .acc_len(acc_len),
    .data_r(data_r), .data_i(data_i), .ovalid(ov2), .result_r(r2), .result_i(i2), .overflow(of2));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drv(input logic v, input logic c, input int dr, input int di);
    ivalid = v;
    clear  = c;
    data_r = dr;
    data_i = di;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    reset = 1'b1; ivalid = 1'b0; clear = 1'b0; acc_len = 8'd1; data_r = 0; data_i = 0;
    #1;
    chk("reset_ovalid", 64'(ov0), 0);
    chk("reset_r", r0, 0);
    chk("reset_i", i0, 0);
    chk("reset_ovf", 64'(of0), 0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Basic 4-sample frame
    acc_len = 8'd4;
    drv(1, 0, 1, 2);
    drv(1, 0, 3, 4);
    drv(1, 0, 5, 6);
    drv(1, 0, 7, 8);
    chk("basic_not_early", 64'(ov0), 0);
    idle();
    chk("basic_ovalid", 64'(ov0), 1);
    chk("basic_r", r0, 16);
    chk("basic_i", i0, 20);
    chk("basic_ovf", 64'(of0), 0);
    idle();
    chk("basic_pulse_end", 64'(ov0), 0);
    chk("basic_hold_r", r0, 16);

    // Gapped input with signs
    acc_len = 8'd3;
    drv(1, 0, -5, 2);
    idle();
    chk("gap_ov1", 64'(ov0), 0);
    idle();
    chk("gap_ov2", 64'(ov0), 0);
    drv(1, 0, 3, -7);
    chk("gap_ov3", 64'(ov0), 0);
    drv(1, 0, -1, -1);
    idle();
    chk("gap_ovalid", 64'(ov0), 1);
    chk("gap_r", r0, -3);
    chk("gap_i", i0, -6);

    // Back-to-back frames with a length change mid-frame
    acc_len = 8'd2;
    drv(1, 0, 10, 10);
    acc_len = 8'd1;
    drv(1, 0, 5, 5);
    chk("b2b_not_early", 64'(ov0), 0);
    drv(1, 0, 1, 0);
    chk("b2b_f1_ovalid", 64'(ov0), 1);
    chk("b2b_f1_r", r0, 15);
    chk("b2b_f1_i", i0, 15);
    drv(1, 0, 2, 0);
    chk("b2b_f2_ovalid", 64'(ov0), 1);
    chk("b2b_f2_r", r0, 1);
    chk("b2b_f2_i", i0, 0);
    idle();
    chk("b2b_f3_ovalid", 64'(ov0), 1);
    chk("b2b_f3_r", r0, 2);
    idle();
    chk("b2b_end", 64'(ov0), 0);

    // Saturation on the 16-bit instance, none on the 32-bit one
    acc_len = 8'd2;
    drv(1, 0, 30000, -30000);
    drv(1, 0, 30000, -30000);
    idle();
    chk("sat_ovalid", 64'(ov1), 1);
    chk("sat_r", r1, 32767);
    chk("sat_i", i1, -32768);
    chk("sat_ovf", 64'(of1), 1);
    chk("nosat_r", r0, 60000);
    chk("nosat_ovf", 64'(of0), 0);
    idle();
    chk("sat_ovf_clear", 64'(of1), 0);

    // clear with a simultaneous sample restarts the frame
    acc_len = 8'd3;
    drv(1, 0, 1, 1);
    drv(1, 0, 1, 1);
    drv(1, 1, 4, 4);
    drv(1, 0, 1, 1);
    chk("clr_no_dump_a", 64'(ov0), 0);
    drv(1, 0, 1, 1);
    chk("clr_no_dump_b", 64'(ov0), 0);
    idle();
    chk("clr_ovalid", 64'(ov0), 1);
    chk("clr_r", r0, 6);
    chk("clr_i", i0, 6);

    // acc_len = 0 behaves as 1
    acc_len = 8'd0;
    drv(1, 0, 7, -3);
    drv(1, 0, -2, 9);
    chk("len0_a_ovalid", 64'(ov0), 1);
    chk("len0_a_r", r0, 7);
    chk("len0_a_i", i0, -3);
    idle();
    chk("len0_b_r", r0, -2);
    chk("len0_b_i", i0, 9);

    // Rounding versus floor on the SHIFT=2 instance
    acc_len = 8'd1;
    drv(1, 0, 6, -6);
    idle();
    chk("shift_ovalid", 64'(ov2), 1);
`ifdef CMPL_ACC_ROUND_EN
    chk("shift_r", r2, 2);
    chk("shift_i", i2, -1);
`else
    chk("shift_r", r2, 1);
    chk("shift_i", i2, -2);
`endif
    chk("shift0_r", r0, 6);
    chk("shift0_i", i0, -6);

    // Reset mid-frame discards the partial sum
    acc_len = 8'd3;
    drv(1, 0, 100, 100);
    ivalid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_async_r", r0, 0);
    chk("rst_async_ovalid", 64'(ov0), 0);
    #2 reset = 1'b0;
    @(posedge clock);
    #1;
    drv(1, 0, 1, 2);
    drv(1, 0, 3, 4);
    chk("rst_no_dump", 64'(ov0), 0);
    drv(1, 0, 5, 6);
    chk("rst_no_dump2", 64'(ov0), 0);
    idle();
    chk("rst_ovalid", 64'(ov0), 1);
    chk("rst_r", r0, 9);
    chk("rst_i", i0, 12);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
